register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 84 ++++++++
 tb/tb_register_file.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit register file with two combinational read ports, one writeback port
// and a pending-write (busy) scoreboard. Define REGISTER_FILE_BYPASS_EN for write-to-read bypass.
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_reg_en,
    input  logic [4:0]  wb_reg_addr,
    input  logic [31:0] wb_reg_data,
    input  logic [4:0]  id_reg_addr1,
    input  logic [4:0]  id_reg_addr2,
    output logic [31:0] id_reg_data1,
    output logic [31:0] id_reg_data2,
    input  logic        id_mark_en,
    input  logic [4:0]  id_mark_addr,
    output logic        id_reg_busy1,
    output logic        id_reg_busy2
);

    logic [31:0][31:0] regs_q, regs_d;
    logic [31:0]       busy_q, busy_d;

    logic wb_hit;
    logic mark_hit;

    assign wb_hit   = wb_reg_en  && (wb_reg_addr  != 5'd0);
    assign mark_hit = id_mark_en && (id_mark_addr != 5'd0);

    // NOTE: every always_comb output is given its hold value first, so no path infers a latch.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_hit) begin
            regs_d[wb_reg_addr] = wb_reg_data;
            busy_d[wb_reg_addr] = 1'b0;
        end
        // Applied after the clear so a same-register mark wins.
        if (mark_hit) begin
            busy_d[id_mark_addr] = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments. The storage is built from flops, not a
    // RAM macro, so clearing the whole array in one reset cycle is legal and intended.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [31:0] stored_data1, stored_data2;
    logic        stored_busy1, stored_busy2;

    // Register 0 is never written and never marked, so its stored entry stays zero.
    assign stored_data1 = regs_q[id_reg_addr1];
    assign stored_data2 = regs_q[id_reg_addr2];
    assign stored_busy1 = busy_q[id_reg_addr1];
    assign stored_busy2 = busy_q[id_reg_addr2];

`ifdef REGISTER_FILE_BYPASS_EN
    logic byp1, byp2;

    assign byp1 = rst_n && wb_hit && (wb_reg_addr == id_reg_addr1);
    assign byp2 = rst_n && wb_hit && (wb_reg_addr == id_reg_addr2);

    always_comb begin
        id_reg_data1 = byp1 ? wb_reg_data : stored_data1;
        id_reg_data2 = byp2 ? wb_reg_data : stored_data2;
        id_reg_busy1 = byp1 ? 1'b0 : stored_busy1;
        id_reg_busy2 = byp2 ? 1'b0 : stored_busy2;
    end
`else
    always_comb begin
        id_reg_data1 = stored_data1;
        id_reg_data2 = stored_data2;
        id_reg_busy1 = stored_busy1;
        id_reg_busy2 = stored_busy2;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read results are queued as stimulus is driven
// and compared against sampled port values in each scenario task.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic [4:0]  id_reg_addr1;
    logic [4:0]  id_reg_addr2;
    logic [31:0] id_reg_data1;
    logic [31:0] id_reg_data2;
    logic        id_mark_en;
    logic [4:0]  id_mark_addr;
    logic        id_reg_busy1;
    logic        id_reg_busy2;

    register_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_reg_en    (wb_reg_en),
        .wb_reg_addr  (wb_reg_addr),
        .wb_reg_data  (wb_reg_data),
        .id_reg_addr1 (id_reg_addr1),
        .id_reg_addr2 (id_reg_addr2),
        .id_reg_data1 (id_reg_data1),
        .id_reg_data2 (id_reg_data2),
        .id_mark_en   (id_mark_en),
        .id_mark_addr (id_mark_addr),
        .id_reg_busy1 (id_reg_busy1),
        .id_reg_busy2 (id_reg_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
    } rd_t;

    rd_t   exp_q[$];
    rd_t   obs_q[$];
    string name_q[$];
    rd_t   e, o;
    string nm;
    int    n_tests = 0;
    int    n_fail  = 0;
    logic [31:0] model [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_reg_en    = 1'b0;
        wb_reg_addr  = 5'd0;
        wb_reg_data  = 32'd0;
        id_mark_en   = 1'b0;
        id_mark_addr = 5'd0;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] d1, input logic b1,
                             input logic [31:0] d2, input logic b2);
        exp_q.push_back({d1, b1, d2, b2});
        name_q.push_back(name);
    endtask

    task automatic observe();
        @(negedge clk);
        obs_q.push_back({id_reg_data1, id_reg_busy1, id_reg_data2, id_reg_busy2});
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd5;
        wb_reg_data  = 32'hFFFF_FFFF;
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd6;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 32; i++) begin
            id_reg_addr1 = 5'(i);
            id_reg_addr2 = 5'(31 - i);
            expect_rd($sformatf("reset_r%0d", i), 32'd0, 1'b0, 32'd0, 1'b0);
            observe();
            tick();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b, required d1=%h b1=%b d2=%h b2=%b",
                         nm, o.d1, o.b1, o.d2, o.b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd5;
        wb_reg_data  = 32'hDEAD_BEEF;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        wb_reg_addr  = 5'd31;
        wb_reg_data  = 32'h8000_0001;
        id_reg_addr1 = 5'd5;
        id_reg_addr2 = 5'd5;
        expect_rd("write_r5_both_ports", 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        observe();
        tick();
        // Write to r0 while reading it: no bypass, no storage.
        wb_reg_addr  = 5'd0;
        wb_reg_data  = 32'h1234_5678;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd31;
        expect_rd("write_r0_same_cycle", 32'd0, 1'b0, 32'h8000_0001, 1'b0);
        observe();
        tick();
        idle();
        expect_rd("write_r0_next_cycle", 32'd0, 1'b0, 32'h8000_0001, 1'b0);
        observe();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b, required d1=%h b1=%b d2=%h b2=%b",
                         nm, o.d1, o.b1, o.d2, o.b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    endtask

    task automatic test_mark_clear();
        idle();
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd7;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        id_mark_addr = 5'd0;
        id_reg_addr1 = 5'd7;
        id_reg_addr2 = 5'd0;
        expect_rd("mark_r7_busy", 32'd0, 1'b1, 32'd0, 1'b0);
        observe();
        tick();
        idle();
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd7;
        wb_reg_data  = 32'h55;
        id_reg_addr1 = 5'd8;
        tick();
        idle();
        id_reg_addr1 = 5'd7;
        id_reg_addr2 = 5'd0;
        expect_rd("clear_r7_after_wb", 32'h55, 1'b0, 32'd0, 1'b0);
        observe();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b, required d1=%h b1=%b d2=%h b2=%b",
                         nm, o.d1, o.b1, o.d2, o.b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    endtask

    task automatic test_mark_wins();
        idle();
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd9;
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd9;
        wb_reg_data  = 32'hA;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        idle();
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd11;
        id_reg_addr1 = 5'd9;
        id_reg_addr2 = 5'd9;
        expect_rd("mark_wins_r9", 32'hA, 1'b1, 32'hA, 1'b1);
        observe();
        tick();
        // Mark r10 and clear r11 in the same cycle; also mark r12 and r0.
        id_mark_addr = 5'd10;
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd11;
        wb_reg_data  = 32'hB;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        idle();
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd12;
        id_reg_addr1 = 5'd10;
        id_reg_addr2 = 5'd11;
        expect_rd("mark_clear_diff_regs", 32'd0, 1'b1, 32'hB, 1'b0);
        observe();
        tick();
        id_mark_addr = 5'd12;
        tick();
        idle();
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd0;
        id_reg_addr1 = 5'd12;
        id_reg_addr2 = 5'd0;
        expect_rd("double_mark_r12", 32'd0, 1'b1, 32'd0, 1'b0);
        observe();
        tick();
        idle();
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd12;
        wb_reg_data  = 32'hC;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        idle();
        id_reg_addr1 = 5'd12;
        id_reg_addr2 = 5'd0;
        expect_rd("single_clear_r12_r0_never_busy", 32'hC, 1'b0, 32'd0, 1'b0);
        observe();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b, required d1=%h b1=%b d2=%h b2=%b",
                         nm, o.d1, o.b1, o.d2, o.b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd3;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        idle();
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd3;
        wb_reg_data  = 32'hCAFE;
        id_reg_addr1 = 5'd3;
        id_reg_addr2 = 5'd3;
`ifdef REGISTER_FILE_BYPASS_EN
        expect_rd("same_cycle_r3", 32'hCAFE, 1'b0, 32'hCAFE, 1'b0);
`else
        expect_rd("same_cycle_r3", 32'd0, 1'b1, 32'd0, 1'b1);
`endif
        observe();
        tick();
        wb_reg_addr  = 5'd13;
        wb_reg_data  = 32'h77;
        id_reg_addr1 = 5'd13;
        id_reg_addr2 = 5'd3;
`ifdef REGISTER_FILE_BYPASS_EN
        expect_rd("next_cycle_r3_port1_r13", 32'h77, 1'b0, 32'hCAFE, 1'b0);
`else
        expect_rd("next_cycle_r3_port1_r13", 32'd0, 1'b0, 32'hCAFE, 1'b0);
`endif
        observe();
        tick();
        idle();
        id_reg_addr1 = 5'd13;
        id_reg_addr2 = 5'd3;
        expect_rd("after_r13_write", 32'h77, 1'b0, 32'hCAFE, 1'b0);
        observe();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b, required d1=%h b1=%b d2=%h b2=%b",
                         nm, o.d1, o.b1, o.d2, o.b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] val;
        for (int r = 0; r < 32; r++) model[r] = 32'd0;
        idle();
        for (int i = 0; i < 8; i++) begin
            val          = $urandom();
            wb_reg_en    = 1'b1;
            wb_reg_addr  = 5'(16 + i);
            wb_reg_data  = val;
            id_reg_addr1 = 5'(15 + i);
            id_reg_addr2 = 5'd0;
            expect_rd($sformatf("b2b_prev_r%0d", 15 + i), model[15 + i], 1'b0, 32'd0, 1'b0);
            observe();
            model[16 + i] = val;
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            id_reg_addr1 = 5'(16 + i);
            id_reg_addr2 = 5'(23 - i);
            expect_rd($sformatf("b2b_read_r%0d", 16 + i), model[16 + i], 1'b0,
                      model[23 - i], 1'b0);
            observe();
            tick();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b, required d1=%h b1=%b d2=%h b2=%b",
                         nm, o.d1, o.b1, o.d2, o.b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd4;
        wb_reg_data  = 32'h1;
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd4;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        tick();
        // Reset cycle with a write and mark presented: both discarded, no bypass.
        rst_n        = 1'b0;
        wb_reg_en    = 1'b1;
        wb_reg_addr  = 5'd4;
        wb_reg_data  = 32'h99;
        id_mark_en   = 1'b1;
        id_mark_addr = 5'd5;
        id_reg_addr1 = 5'd4;
        id_reg_addr2 = 5'd5;
        expect_rd("in_reset_stored_values", 32'h1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        observe();
        tick();
        rst_n = 1'b1;
        idle();
        id_reg_addr1 = 5'd4;
        id_reg_addr2 = 5'd5;
        expect_rd("after_mid_reset_r4_r5", 32'd0, 1'b0, 32'd0, 1'b0);
        observe();
        tick();
        id_reg_addr1 = 5'd9;
        id_reg_addr2 = 5'd3;
        expect_rd("after_mid_reset_r9_r3", 32'd0, 1'b0, 32'd0, 1'b0);
        observe();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b, required d1=%h b1=%b d2=%h b2=%b",
                         nm, o.d1, o.b1, o.d2, o.b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        id_reg_addr1 = 5'd0;
        id_reg_addr2 = 5'd0;
        idle();
        test_reset();
        test_write_read();
        test_mark_clear();
        test_mark_wins();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
